// File: rtl/dma_copy_engine.sv
// Memory-to-memory DMA copy engine: register slave for setup and
// bus master that copies LEN words in bursts through a staging buffer.
module dma_copy_engine #(
  parameter logic [31:0] base_addr = 32'h0000_0000,
  parameter logic [31:0] addr_mask = 32'hFFFF_FFE0,
  parameter int          BURST     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        s_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        irq
);

  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RD, WR, DONE} state_t;

  state_t        state;
  logic [31:0]   src, dst, cur_src, cur_dst;
  logic [15:0]   len, remaining, bn;
  logic          irq_en, done, busy, abort_q;
  logic [IW-1:0] idx;
  logic [31:0]   wbuf [BURST];

  logic        sel, ctrl_wr, start_hit, abort_hit, last;
  logic [31:0] off;

  assign sel       = s_req && ((s_addr & addr_mask) == base_addr);
  assign off       = s_addr & ~addr_mask;
  assign ctrl_wr   = sel && s_we && (off == 32'h0C);
  assign start_hit = ctrl_wr && s_wdata[0];
  assign abort_hit = ctrl_wr && s_wdata[2];
  assign last      = (16'(idx) + 16'd1) == bn;
  assign irq       = done & irq_en;

  function automatic logic [15:0] bsz(input logic [15:0] r);
    return (r > 16'(BURST)) ? 16'(BURST) : r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      bn        <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      abort_q   <= 1'b0;
      idx       <= '0;
      s_ack     <= 1'b0;
      s_rdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      for (int i = 0; i < BURST; i++) wbuf[i] <= '0;
    end else begin
      s_ack   <= sel;
      s_rdata <= '0;
      if (sel && !s_we) begin
        unique case (1'b1)
          off == 32'h00: s_rdata <= src;
          off == 32'h04: s_rdata <= dst;
          off == 32'h08: s_rdata <= {16'd0, len};
          off == 32'h0C: s_rdata <= {30'd0, irq_en, 1'b0};
          off == 32'h10: s_rdata <= {remaining, 14'd0, done, busy};
          default:       s_rdata <= '0;
        endcase
      end
      if (sel && s_we && state == IDLE) begin
        if (off == 32'h00) src <= {s_wdata[31:2], 2'b00};
        if (off == 32'h04) dst <= {s_wdata[31:2], 2'b00};
        if (off == 32'h08) len <= s_wdata[15:0];
      end
      if (ctrl_wr) irq_en <= s_wdata[1];
      if (ctrl_wr && s_wdata[3]) done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_hit && !abort_hit) begin
            done  <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          remaining <= len;
          if (abort_hit) begin
            state <= IDLE;
          end else begin
            cur_src <= src;
            cur_dst <= dst;
            busy    <= 1'b1;
            idx     <= '0;
            bn      <= bsz(len);
            state   <= (len == 16'd0) ? DONE : RD;
          end
        end
        RD: begin
          if (m_req) begin
            if (m_ack) begin
              m_req <= 1'b0;
              if (abort_q || abort_hit) begin
                abort_q <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                wbuf[idx] <= m_rdata;
                cur_src   <= cur_src + 32'd4;
                idx       <= last ? '0 : idx + IW'(1);
                if (last) state <= WR;
              end
            end else if (abort_hit) begin
              abort_q <= 1'b1;
            end
          end else if (abort_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= cur_src;
          end
        end
        WR: begin
          if (m_req) begin
            if (m_ack) begin
              m_req <= 1'b0;
              if (abort_q || abort_hit) begin
                abort_q <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                cur_dst   <= cur_dst + 32'd4;
                remaining <= remaining - 16'd1;
                idx       <= last ? '0 : idx + IW'(1);
                if (last) begin
                  bn    <= bsz(remaining - 16'd1);
                  state <= (remaining == 16'd1) ? DONE : RD;
                end
              end
            end else if (abort_hit) begin
              abort_q <= 1'b1;
            end
          end else if (abort_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            m_req   <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= cur_dst;
            m_wdata <= wbuf[idx];
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
